// File: rtl/tsn_npu_pkg.sv
// tsn_npu_pkg: shared types and constants for the TSN-NPU DMA scheduler
package tsn_npu_pkg;
  localparam int DRAM_ADDR_W = 40;
  localparam int DPRAM_ADDR_W = 16;
  localparam int LEN_W = 16;
  localparam int BEAT_BYTES = 16;
  localparam int BLEN_W = 9;
  typedef enum logic [1:0] {IDLE, SPLIT, DRAIN, DONE} state_e;
  typedef struct packed {
    logic                    write;
    logic [DRAM_ADDR_W-1:0]  dram_addr;
    logic [DPRAM_ADDR_W-1:0] dpram_addr;
    logic [BLEN_W-1:0]       len;
  } burst_t;
endpackage

// File: rtl/tsn_rr_pick.sv
// tsn_rr_pick: round-robin grant over a 4-bit eligible mask starting at ptr
module tsn_rr_pick (
  input  logic [3:0] eligible,
  input  logic [1:0] ptr,
  output logic [1:0] grant,
  output logic       grant_valid
);
  logic [1:0] idx;
  always_comb begin
    grant = 2'd0;
    grant_valid = 1'b0;
    idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (eligible[idx]) begin
        grant = idx;
        grant_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/tsn_dma_sched.sv
// tsn_dma_sched: splits DMA commands into bursts and issues them round-robin to four channels
module tsn_dma_sched #(
  parameter int NUM_CH = 4,
  parameter int MAX_BURST = 16,
  parameter int BEAT_BYTES = 16,
  parameter int ADDR_W = 40
) (
  input  logic                     fpu_clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDR_W-1:0]        cmd_dram_addr,
  input  logic [15:0]              cmd_dpram_addr,
  input  logic [15:0]              cmd_length,
  output logic                     cmd_done,
  input  logic [NUM_CH-1:0]        ch_enable,
  output logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_resp,
  output logic [NUM_CH-1:0]        ch_write,
  output logic [NUM_CH*ADDR_W-1:0] ch_dram_addr,
  output logic [NUM_CH*16-1:0]     ch_dpram_addr,
  output logic [NUM_CH*9-1:0]      ch_length,
  output logic                     busy,
  output logic                     err_spurious
);
  import tsn_npu_pkg::*;
  localparam logic [LEN_W-1:0] MAXB = LEN_W'(MAX_BURST);
  state_e state_q, state_d;
  logic [1:0] rr_q, rr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] dram_q, dram_d;
  logic [15:0] dpram_q, dpram_d;
  logic wr_q, wr_d;
  logic [NUM_CH-1:0] req_q, req_d;
  logic done_q, done_d;
  logic spur_q, spur_d;
  burst_t burst_q [NUM_CH];
  burst_t burst_d [NUM_CH];
  logic [BLEN_W-1:0] blen;
  logic [1:0] gnt;
  logic gnt_vld;
  tsn_rr_pick u_pick (
    .eligible    (ch_enable & ~req_q),
    .ptr         (rr_q),
    .grant       (gnt),
    .grant_valid (gnt_vld)
  );
  assign blen = (rem_q > MAXB) ? BLEN_W'(MAX_BURST) : rem_q[BLEN_W-1:0];
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    rem_d = rem_q;
    dram_d = dram_q;
    dpram_d = dpram_q;
    wr_d = wr_q;
    burst_d = burst_q;
    done_d = 1'b0;
    req_d = req_q & ~ch_resp;
    spur_d = spur_q | (|(ch_resp & ~req_q));
    case (state_q)
      IDLE: if (cmd_valid && cmd_ready) begin
        wr_d = cmd_write;
        dram_d = cmd_dram_addr;
        dpram_d = cmd_dpram_addr;
        rem_d = cmd_length;
        state_d = (cmd_length == '0) ? DONE : SPLIT;
      end
      SPLIT: if (gnt_vld) begin
        req_d[gnt] = 1'b1;
        burst_d[gnt] = '{write: wr_q, dram_addr: dram_q, dpram_addr: dpram_q, len: blen};
        rr_d = gnt + 2'd1;
        dram_d = dram_q + ADDR_W'(blen) * ADDR_W'(BEAT_BYTES);
        dpram_d = dpram_q + 16'(blen);
        rem_d = rem_q - LEN_W'(blen);
        state_d = (rem_q == LEN_W'(blen)) ? DRAIN : SPLIT;
      end
      DRAIN: state_d = (req_q == '0) ? DONE : DRAIN;
      DONE: begin
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge fpu_clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q <= '0;
      rem_q <= '0;
      dram_q <= '0;
      dpram_q <= '0;
      wr_q <= 1'b0;
      req_q <= '0;
      done_q <= 1'b0;
      spur_q <= 1'b0;
      burst_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      rem_q <= rem_d;
      dram_q <= dram_d;
      dpram_q <= dpram_d;
      wr_q <= wr_d;
      req_q <= req_d;
      done_q <= done_d;
      spur_q <= spur_d;
      burst_q <= burst_d;
    end
  end
  assign cmd_ready = (state_q == IDLE) && !done_q;
  assign busy = (state_q != IDLE);
  assign cmd_done = done_q;
  assign ch_req = req_q;
  assign err_spurious = spur_q;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_write[g] = burst_q[g].write;
    assign ch_dram_addr[g*ADDR_W +: ADDR_W] = burst_q[g].dram_addr;
    assign ch_dpram_addr[g*16 +: 16] = burst_q[g].dpram_addr;
    assign ch_length[g*9 +: 9] = burst_q[g].len;
  end
endmodule

// File: tb/tb_tsn_dma_sched.sv
// tb_tsn_dma_sched: directed checks of burst splitting, round-robin issue, wrap, reset and spurious responses
module tb_tsn_dma_sched;
  logic fpu_clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [39:0] cmd_dram_addr = '0;
  logic [15:0] cmd_dpram_addr = '0, cmd_length = '0;
  logic cmd_ready, cmd_done, busy, err_spurious;
  logic [3:0] ch_enable = 4'hf;
  logic [3:0] ch_req, ch_resp, ch_write;
  logic [3:0] resp_auto = '0, resp_man = '0;
  logic [159:0] ch_dram_addr;
  logic [63:0] ch_dpram_addr;
  logic [35:0] ch_length;
  logic c1_valid = 1'b0;
  logic [39:0] c1_dram = '0;
  logic [15:0] c1_dpram = '0, c1_len = '0;
  logic c1_ready, c1_done, c1_busy, c1_err;
  logic [3:0] ch_req1, ch_resp1, ch_write1;
  logic [159:0] ch_dram1;
  logic [63:0] ch_dpram1;
  logic [35:0] ch_len1;
  int cyc = 0;
  int n_chk = 0, n_pass = 0;
  logic auto_en = 1'b0;
  int n_iss = 0, n_done = 0, done_cyc = 0, hold_bad = 0;
  int lg_ch [32];
  int lg_gap [32];
  logic lg_wr [32];
  logic [39:0] lg_dram [32];
  logic [15:0] lg_dpram [32];
  logic [8:0] lg_len [32];
  int last_resp [4];
  int age [4];
  logic [65:0] hold_prev [4];
  logic [3:0] req_prev = '0, req1_prev = '0;
  int n1 = 0;
  logic [39:0] l1_dram [8];
  logic [15:0] l1_dpram [8];
  logic [8:0] l1_len [8];
  logic [39:0] t1_dram [3] = '{40'h10_0000_0000, 40'h10_0000_0100, 40'h10_0000_0200};
  logic [15:0] t1_dpram [3] = '{16'h0100, 16'h0110, 16'h0120};
  logic [8:0] t1_len [3] = '{9'd16, 9'd16, 9'd8};

  assign ch_resp = resp_auto | resp_man;
  assign ch_resp1 = ch_req1;

  always #5 fpu_clk = ~fpu_clk;
  always @(posedge fpu_clk) cyc <= cyc + 1;

  tsn_dma_sched u_dut (
    .fpu_clk(fpu_clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_dram_addr(cmd_dram_addr), .cmd_dpram_addr(cmd_dpram_addr),
    .cmd_length(cmd_length), .cmd_done(cmd_done), .ch_enable(ch_enable), .ch_req(ch_req),
    .ch_resp(ch_resp), .ch_write(ch_write), .ch_dram_addr(ch_dram_addr),
    .ch_dpram_addr(ch_dpram_addr), .ch_length(ch_length), .busy(busy), .err_spurious(err_spurious)
  );

  tsn_dma_sched #(.MAX_BURST(1)) u_dut1 (
    .fpu_clk(fpu_clk), .reset(reset), .cmd_valid(c1_valid), .cmd_ready(c1_ready),
    .cmd_write(1'b0), .cmd_dram_addr(c1_dram), .cmd_dpram_addr(c1_dpram),
    .cmd_length(c1_len), .cmd_done(c1_done), .ch_enable(4'hf), .ch_req(ch_req1),
    .ch_resp(ch_resp1), .ch_write(ch_write1), .ch_dram_addr(ch_dram1),
    .ch_dpram_addr(ch_dpram1), .ch_length(ch_len1), .busy(c1_busy), .err_spurious(c1_err)
  );

  always @(negedge fpu_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ch_req[i] && !req_prev[i] && n_iss < 32) begin
        lg_ch[n_iss] = i;
        lg_wr[n_iss] = ch_write[i];
        lg_dram[n_iss] = ch_dram_addr[i*40 +: 40];
        lg_dpram[n_iss] = ch_dpram_addr[i*16 +: 16];
        lg_len[n_iss] = ch_length[i*9 +: 9];
        lg_gap[n_iss] = cyc - last_resp[i];
        n_iss++;
      end
      if (ch_req[i] && req_prev[i] &&
          {ch_write[i], ch_dram_addr[i*40 +: 40], ch_dpram_addr[i*16 +: 16], ch_length[i*9 +: 9]} != hold_prev[i])
        hold_bad++;
      hold_prev[i] = {ch_write[i], ch_dram_addr[i*40 +: 40], ch_dpram_addr[i*16 +: 16], ch_length[i*9 +: 9]};
      resp_auto[i] = auto_en && ch_req[i] && age[i] == 3;
      if (resp_auto[i]) last_resp[i] = cyc;
      age[i] = ch_req[i] ? age[i] + 1 : 0;
    end
    req_prev = ch_req;
    if (cmd_done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  always @(negedge fpu_clk) begin
    for (int i = 0; i < 4; i++)
      if (ch_req1[i] && !req1_prev[i] && n1 < 8) begin
        l1_dram[n1] = ch_dram1[i*40 +: 40];
        l1_dpram[n1] = ch_dpram1[i*16 +: 16];
        l1_len[n1] = ch_len1[i*9 +: 9];
        n1++;
      end
    req1_prev = ch_req1;
  end

  task automatic tick();
    @(negedge fpu_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic send(input logic wr, input logic [39:0] da, input logic [15:0] pa,
                      input logic [15:0] len, output int acc);
    int k = 0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_dram_addr = da;
    cmd_dpram_addr = pa;
    cmd_length = len;
    while (!cmd_ready && k < 100) begin
      tick();
      k++;
    end
    chk("send_ready", cmd_ready, 1);
    acc = cyc;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int d0 = n_done;
    int k = 0;
    while (n_done == d0 && k < 300) begin
      tick();
      k++;
    end
    chk({tag, "_no_timeout"}, k < 300, 1);
    repeat (5) tick();
  endtask

  initial begin
    int acc, base, d0, k;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ch_req", ch_req, 0);
    chk("rst_cmd_done", cmd_done, 0);
    chk("rst_err", err_spurious, 0);
    chk("rst_dram", ch_dram_addr[63:0], 0);
    chk("rst_len", ch_length, 0);

    auto_en = 1'b1;
    base = n_iss;
    d0 = n_done;
    send(1'b0, 40'h10_0000_0000, 16'h0100, 16'd40, acc);
    wait_done("t1");
    chk("t1_bursts", n_iss - base, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t1_ch%0d", i), lg_ch[base+i], i);
      chk($sformatf("t1_wr%0d", i), lg_wr[base+i], 0);
      chk($sformatf("t1_dram%0d", i), lg_dram[base+i], t1_dram[i]);
      chk($sformatf("t1_dpram%0d", i), lg_dpram[base+i], t1_dpram[i]);
      chk($sformatf("t1_len%0d", i), lg_len[base+i], t1_len[i]);
    end
    chk("t1_one_done", n_done - d0, 1);
    chk("t1_done_after_resp", done_cyc > last_resp[2], 1);

    tick();
    c1_valid = 1'b1;
    c1_dram = 40'hFF_FFFF_FFF0;
    c1_dpram = 16'hFFFF;
    c1_len = 16'd2;
    chk("t4_ready", c1_ready, 1);
    tick();
    c1_valid = 1'b0;
    repeat (12) tick();
    chk("t4_bursts", n1, 2);
    chk("t4_dram0", l1_dram[0], 40'hFF_FFFF_FFF0);
    chk("t4_dpram0", l1_dpram[0], 16'hFFFF);
    chk("t4_dram1", l1_dram[1], 40'h0);
    chk("t4_dpram1", l1_dpram[1], 16'h0);
    chk("t4_len1", l1_len[1], 1);
    chk("t4_no_err", c1_err, 0);

    ch_enable = 4'b0100;
    base = n_iss;
    send(1'b1, 40'h20_0000_0000, 16'h0200, 16'd48, acc);
    wait_done("t2");
    chk("t2_bursts", n_iss - base, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t2_ch%0d", i), lg_ch[base+i], 2);
      chk($sformatf("t2_wr%0d", i), lg_wr[base+i], 1);
      chk($sformatf("t2_len%0d", i), lg_len[base+i], 16);
      chk($sformatf("t2_dram%0d", i), lg_dram[base+i], 40'h20_0000_0000 + 40'(i * 256));
      if (i > 0) chk($sformatf("t2_gap%0d", i), lg_gap[base+i], 2);
    end
    chk("t2_hold", hold_bad, 0);

    ch_enable = 4'hf;
    base = n_iss;
    send(1'b0, 40'h0, 16'h0, 16'd0, acc);
    k = 0;
    while (!cmd_done && k < 20) begin
      tick();
      k++;
    end
    chk("t3_done_lat", cyc - acc, 2);
    chk("t3_ready_at_done", cmd_ready, 0);
    tick();
    chk("t3_ready_after", cmd_ready, 1);
    chk("t3_done_pulse", cmd_done, 0);
    chk("t3_no_req", n_iss - base, 0);

    resp_man = 4'b0010;
    tick();
    resp_man = 4'b0000;
    tick();
    chk("t5_err_set", err_spurious, 1);
    base = n_iss;
    send(1'b0, 40'h40_0000_0000, 16'h0300, 16'd5, acc);
    wait_done("t5");
    chk("t5_rr_wrap_ch", lg_ch[base], 3);
    chk("t5_len", lg_len[base], 5);
    chk("t5_err_sticky", err_spurious, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("t5_err_cleared", err_spurious, 0);

    base = n_iss;
    d0 = n_done;
    send(1'b0, 40'h30_0000_0000, 16'h0000, 16'd32, acc);
    tick();
    tick();
    chk("t6_outstanding", $countones(ch_req), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_req", ch_req, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ready", cmd_ready, 1);
    chk("t6_dram_cleared", ch_dram_addr[79:0], 0);
    chk("t6_first_ch", lg_ch[base], 0);
    chk("t6_second_ch", lg_ch[base+1], 1);
    repeat (8) tick();
    chk("t6_no_done", n_done - d0, 0);
    chk("t6_err_before", err_spurious, 0);
    resp_man = 4'b0001;
    tick();
    resp_man = 4'b0000;
    tick();
    chk("t6_err_late_resp", err_spurious, 1);
    chk("hold_stable", hold_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
